qpu_dtcm_icb_arb: RTL and testbench
===================================

Name: qpu_dtcm_icb_arb

Overview:
- Two-requester ICB arbiter in front of the DTCM controller's single ICB slave port.
- Requester 0 is the LSU data port. Requester 1 is a second data master, e.g. the measurement-result writer or debug loader.
- Round-robin arbitration on the command channel, with grant lock while a command is stalled.
- Responses are routed back in order through an outstanding-ID FIFO. Command and response paths are combinational pass-throughs; only the arbitration state and the ID FIFO are registered.

Parameters:
- AW, 16, DTCM ICB address width; equals the DTCM address width.
- DW, 32, data width; equals the core XLEN.
- OUTS_DEPTH, 2, maximum outstanding commands; power of two, at least 1.
- CW, $clog2(OUTS_DEPTH+1), width of the outstanding counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- r0_icb_cmd_valid / r1_icb_cmd_valid  in  1  requester command valid
- r0_icb_cmd_ready / r1_icb_cmd_ready  out  1  requester command ready
- r0_icb_cmd_addr / r1_icb_cmd_addr  in  AW  command address
- r0_icb_cmd_read / r1_icb_cmd_read  in  1  1 = read, 0 = write
- r0_icb_cmd_wdata / r1_icb_cmd_wdata  in  DW  write data
- r0_icb_cmd_wmask / r1_icb_cmd_wmask  in  DW/8  byte write mask
- r0_icb_rsp_valid / r1_icb_rsp_valid  out  1  response valid
- r0_icb_rsp_ready / r1_icb_rsp_ready  in  1  response ready
- r0_icb_rsp_rdata / r1_icb_rsp_rdata  out  DW  response read data
- dtcm_icb_cmd_valid  out  1  downstream command valid
- dtcm_icb_cmd_ready  in  1  downstream command ready
- dtcm_icb_cmd_addr  out  AW  downstream address
- dtcm_icb_cmd_read  out  1  downstream read flag
- dtcm_icb_cmd_wdata  out  DW  downstream write data
- dtcm_icb_cmd_wmask  out  DW/8  downstream byte mask
- dtcm_icb_rsp_valid  in  1  downstream response valid
- dtcm_icb_rsp_ready  out  1  downstream response ready
- dtcm_icb_rsp_rdata  in  DW  downstream read data
- arb_active  out  1  any cmd valid or outstanding count nonzero; feeds clock-gate enable
- arb_err  out  1  sticky: response received with no outstanding command
- outs_cnt  out  CW  current outstanding command count

Behaviour:
- Single clock domain (clk). rst_n is asynchronous assert, active-low; all state clears immediately.
- Reset values:
  - last_gnt = 1, so requester 0 wins the first tie.
  - lock = 0.
  - ID FIFO empty; outs_cnt = 0; arb_err = 0.
  - All valid/ready outputs evaluate to 0 while no request is present.
- Grant selection, when unlocked:
  - Exactly one valid requester: grant it.
  - Both valid: grant the requester other than last_gnt.
  - When locked, hold the current grant.
- Command path:
  - dtcm_icb_cmd_valid = granted valid AND NOT fifo_full.
  - Payload is muxed from the granted requester.
  - Granted requester's cmd_ready = dtcm_icb_cmd_ready AND NOT fifo_full. The other requester's ready = 0.
  - fifo_full blocks commands even if a response pops in the same cycle (no same-cycle bypass).
- Lock: set when dtcm_icb_cmd_valid=1 and dtcm_icb_cmd_ready=0. Cleared on the command handshake. The grant therefore never switches while a command is stalled.
- On command handshake: push the granted ID into the FIFO, last_gnt <= granted ID, outs_cnt += 1.
- Response path (in order):
  - FIFO head ID selects the target requester.
  - rX_icb_rsp_valid = dtcm_icb_rsp_valid AND fifo nonempty AND head == X.
  - dtcm_icb_rsp_ready = ready of the head requester.
  - rdata is broadcast to both requesters.
  - On response handshake: pop the FIFO, outs_cnt -= 1.
- Push and pop in the same cycle: outs_cnt unchanged; FIFO pointers both advance with wrap-around modulo OUTS_DEPTH.
- Spurious response (dtcm_icb_rsp_valid with FIFO empty):
  - dtcm_icb_rsp_ready = 1 and the response is dropped.
  - arb_err <= 1 and stays set until reset.
- Latency: 0 added cycles on both cmd and rsp paths. Throughput: 1 command per cycle while not full.
- Reset mid-transaction: in-flight IDs are discarded. A late downstream response after reset sets arb_err; the integration requirement is to reset the DTCM controller together with this block.

Test Plan:
1. Only r0 issues 4 back-to-back reads to 0x0010..0x001C, dtcm_icb_cmd_ready=1, rsp returned 1 cycle later -> all routed to r0 in order; r1_icb_rsp_valid stays 0; outs_cnt never exceeds 1.
2. r0 and r1 both valid continuously for 6 cycles -> grant order r0, r1, r0, r1, r0, r1; last_gnt alternates each handshake.
3. r1 granted, dtcm_icb_cmd_ready=0 for 3 cycles while r0 raises valid -> dtcm addr/data stay r1's; r0_icb_cmd_ready=0; after the handshake r0 is granted next.
4. OUTS_DEPTH=2, two commands accepted with no response -> outs_cnt=2, dtcm_icb_cmd_valid=0 with a third request pending. Return one response -> third command accepted the following cycle, not the same cycle.
5. Responses held with r0_icb_rsp_ready=0 for 2 cycles -> dtcm_icb_rsp_ready=0; FIFO head unchanged; rdata 0xDEADBEEF delivered to r0 when ready rises.
6. Inject dtcm_icb_rsp_valid with outs_cnt=0 -> dtcm_icb_rsp_ready=1, no rX_icb_rsp_valid, arb_err=1 and sticky. Assert rst_n=0 mid-burst -> outs_cnt=0 and arb_err=0 immediately, asynchronously.

Source files
------------

// File: rtl/qpu_dtcm_icb_arb_if.sv
// One ICB link (command + response channels) between a master and a slave.
interface qpu_dtcm_icb_arb_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_read;
    logic [DW-1:0] cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/qpu_dtcm_icb_arb.sv
// Two-requester round-robin ICB arbiter in front of the DTCM slave port.
// Responses return in order, steered by a FIFO of granted requester IDs.
module qpu_dtcm_icb_arb #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 2,
    parameter int CW         = $clog2(OUTS_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    qpu_dtcm_icb_arb_if.slave          r0_icb,
    qpu_dtcm_icb_arb_if.slave          r1_icb,
    qpu_dtcm_icb_arb_if.master         dtcm_icb,
    output logic                       arb_active,
    output logic                       arb_err,
    output logic [CW-1:0]              outs_cnt
);
    localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;

    logic                  gnt, gnt_q, last_gnt, lock;
    logic                  gnt_valid, full, empty, push, pop, head;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [OUTS_DEPTH-1:0] id_fifo;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (outs_cnt == CW'(OUTS_DEPTH));
    assign empty = (outs_cnt == '0);
    assign head  = id_fifo[rd_ptr];

    // Locked grant holds through a stall; otherwise rotate away from last_gnt.
    always_comb begin
        gnt = ~last_gnt;
        if (lock)
            gnt = gnt_q;
        else if (r0_icb.cmd_valid && !r1_icb.cmd_valid)
            gnt = 1'b0;
        else if (r1_icb.cmd_valid && !r0_icb.cmd_valid)
            gnt = 1'b1;
    end

    assign gnt_valid          = gnt ? r1_icb.cmd_valid : r0_icb.cmd_valid;
    assign dtcm_icb.cmd_valid = gnt_valid && !full;
    assign dtcm_icb.cmd_addr  = gnt ? r1_icb.cmd_addr  : r0_icb.cmd_addr;
    assign dtcm_icb.cmd_read  = gnt ? r1_icb.cmd_read  : r0_icb.cmd_read;
    assign dtcm_icb.cmd_wdata = gnt ? r1_icb.cmd_wdata : r0_icb.cmd_wdata;
    assign dtcm_icb.cmd_wmask = gnt ? r1_icb.cmd_wmask : r0_icb.cmd_wmask;
    assign r0_icb.cmd_ready   = !gnt && r0_icb.cmd_valid && dtcm_icb.cmd_ready && !full;
    assign r1_icb.cmd_ready   =  gnt && r1_icb.cmd_valid && dtcm_icb.cmd_ready && !full;

    // Responses with nothing outstanding are accepted and dropped.
    assign r0_icb.rsp_valid   = dtcm_icb.rsp_valid && !empty && !head;
    assign r1_icb.rsp_valid   = dtcm_icb.rsp_valid && !empty &&  head;
    assign r0_icb.rsp_rdata   = dtcm_icb.rsp_rdata;
    assign r1_icb.rsp_rdata   = dtcm_icb.rsp_rdata;
    assign dtcm_icb.rsp_ready = empty ? dtcm_icb.rsp_valid
                                      : (head ? r1_icb.rsp_ready : r0_icb.rsp_ready);

    assign push       = dtcm_icb.cmd_valid && dtcm_icb.cmd_ready;
    assign pop        = dtcm_icb.rsp_valid && dtcm_icb.rsp_ready && !empty;
    assign arb_active = r0_icb.cmd_valid || r1_icb.cmd_valid || !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            lock     <= 1'b0;
            gnt_q    <= 1'b0;
        end else if (push) begin
            last_gnt <= gnt;
            lock     <= 1'b0;
        end else if (dtcm_icb.cmd_valid) begin
            lock     <= 1'b1;
            gnt_q    <= gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            id_fifo  <= '0;
            outs_cnt <= '0;
            arb_err  <= 1'b0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= gnt;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                outs_cnt <= outs_cnt + 1'b1;
            else if (pop && !push)
                outs_cnt <= outs_cnt - 1'b1;
            if (dtcm_icb.rsp_valid && empty)
                arb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_qpu_dtcm_icb_arb.sv
// Directed bench for qpu_dtcm_icb_arb: routing, round-robin, lock, full, backpressure, errors.
module tb_qpu_dtcm_icb_arb;
    localparam int AW = 16, DW = 32, OUTS_DEPTH = 2, CW = $clog2(OUTS_DEPTH + 1);

    logic clk = 1'b0, rst_n = 1'b0;
    logic arb_active, arb_err;
    logic [CW-1:0] outs_cnt;
    int n_chk = 0, n_fail = 0;

    qpu_dtcm_icb_arb_if #(.AW(AW), .DW(DW)) r0_if ();
    qpu_dtcm_icb_arb_if #(.AW(AW), .DW(DW)) r1_if ();
    qpu_dtcm_icb_arb_if #(.AW(AW), .DW(DW)) dt_if ();

    qpu_dtcm_icb_arb #(.AW(AW), .DW(DW), .OUTS_DEPTH(OUTS_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_icb(r0_if.slave), .r1_icb(r1_if.slave), .dtcm_icb(dt_if.master),
        .arb_active(arb_active), .arb_err(arb_err), .outs_cnt(outs_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        r0_if.cmd_valid = 0; r0_if.cmd_addr = '0; r0_if.cmd_read = 0;
        r0_if.cmd_wdata = '0; r0_if.cmd_wmask = '0; r0_if.rsp_ready = 1;
        r1_if.cmd_valid = 0; r1_if.cmd_addr = '0; r1_if.cmd_read = 0;
        r1_if.cmd_wdata = '0; r1_if.cmd_wmask = '0; r1_if.rsp_ready = 1;
        dt_if.cmd_ready = 0; dt_if.rsp_valid = 0; dt_if.rsp_rdata = '0;

        // Reset state
        #2;
        chk("rst_outs_cnt", 32'(outs_cnt), 0);
        chk("rst_arb_err", 32'(arb_err), 0);
        chk("rst_dt_cmd_valid", 32'(dt_if.cmd_valid), 0);
        chk("rst_r0_cmd_ready", 32'(r0_if.cmd_ready), 0);
        chk("rst_r0_rsp_valid", 32'(r0_if.rsp_valid), 0);
        chk("rst_dt_rsp_ready", 32'(dt_if.rsp_ready), 0);
        chk("rst_arb_active", 32'(arb_active), 0);
        step(); step();
        rst_n = 1;
        step();

        // 1: r0-only reads, response one cycle behind
        for (int k = 0; k < 5; k++) begin
            r0_if.cmd_valid = (k < 4);
            r0_if.cmd_addr  = 16'h0010 + 16'(4 * k);
            r0_if.cmd_read  = 1;
            dt_if.cmd_ready = 1;
            dt_if.rsp_valid = (k > 0);
            dt_if.rsp_rdata = 32'h1000 + 32'(k);
            #1;
            if (k < 4) begin
                chk("t1_dt_cmd_valid", 32'(dt_if.cmd_valid), 1);
                chk("t1_dt_addr", 32'(dt_if.cmd_addr), 32'h0010 + 32'(4 * k));
                chk("t1_r0_cmd_ready", 32'(r0_if.cmd_ready), 1);
            end
            chk("t1_outs_cnt", 32'(outs_cnt), (k > 0) ? 1 : 0);
            chk("t1_r1_rsp_valid", 32'(r1_if.rsp_valid), 0);
            if (k > 0) begin
                chk("t1_r0_rsp_valid", 32'(r0_if.rsp_valid), 1);
                chk("t1_r0_rdata", r0_if.rsp_rdata, 32'h1000 + 32'(k));
            end
            step();
        end
        dt_if.rsp_valid = 0;
        #1;
        chk("t1_outs_cnt_end", 32'(outs_cnt), 0);

        // 2: both valid, alternate grants from reset (r0 wins first tie)
        rst_n = 0; #2; rst_n = 1;
        step();
        r0_if.cmd_valid = 1; r0_if.cmd_addr = 16'h0100;
        r1_if.cmd_valid = 1; r1_if.cmd_addr = 16'h0200;
        for (int k = 0; k < 6; k++) begin
            dt_if.rsp_valid = (k > 0);
            #1;
            chk("t2_dt_addr", 32'(dt_if.cmd_addr), (k % 2) ? 32'h0200 : 32'h0100);
            chk("t2_r0_cmd_ready", 32'(r0_if.cmd_ready), (k % 2) ? 0 : 1);
            chk("t2_r1_cmd_ready", 32'(r1_if.cmd_ready), (k % 2) ? 1 : 0);
            if (k > 0) begin
                chk("t2_r0_rsp_valid", 32'(r0_if.rsp_valid), ((k - 1) % 2 == 0) ? 1 : 0);
                chk("t2_r1_rsp_valid", 32'(r1_if.rsp_valid), ((k - 1) % 2 == 1) ? 1 : 0);
            end
            step();
        end
        r0_if.cmd_valid = 0; r1_if.cmd_valid = 0;
        #1;
        chk("t2_tail_r1_rsp", 32'(r1_if.rsp_valid), 1);
        step();
        dt_if.rsp_valid = 0;
        #1;
        chk("t2_outs_cnt_end", 32'(outs_cnt), 0);

        // 3: r1 granted and stalled; r0 must wait for r1's handshake
        r1_if.cmd_valid = 1; r1_if.cmd_addr = 16'h0300; r1_if.cmd_read = 0;
        r1_if.cmd_wdata = 32'hA5A5_0001; r1_if.cmd_wmask = 4'hF;
        dt_if.cmd_ready = 0;
        #1;
        chk("t3_dt_addr_first", 32'(dt_if.cmd_addr), 32'h0300);
        step();
        r0_if.cmd_valid = 1; r0_if.cmd_addr = 16'h0400; r0_if.cmd_read = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t3_dt_addr_lock", 32'(dt_if.cmd_addr), 32'h0300);
            chk("t3_dt_wdata_lock", dt_if.cmd_wdata, 32'hA5A5_0001);
            chk("t3_r0_cmd_ready", 32'(r0_if.cmd_ready), 0);
            step();
        end
        dt_if.cmd_ready = 1;
        #1;
        chk("t3_r1_cmd_ready_hs", 32'(r1_if.cmd_ready), 1);
        chk("t3_dt_read_hs", 32'(dt_if.cmd_read), 0);
        step();
        r1_if.cmd_valid = 0;
        #1;
        chk("t3_dt_addr_r0", 32'(dt_if.cmd_addr), 32'h0400);
        chk("t3_r0_cmd_ready_next", 32'(r0_if.cmd_ready), 1);
        step();
        r0_if.cmd_valid = 0;
        dt_if.rsp_valid = 1;
        #1;
        chk("t3_outs_cnt", 32'(outs_cnt), 2);
        chk("t3_rsp_to_r1", 32'(r1_if.rsp_valid), 1);
        step();
        chk("t3_rsp_to_r0", 32'(r0_if.rsp_valid), 1);
        step();
        dt_if.rsp_valid = 0;

        // 4: FIFO full blocks the third command, no same-cycle bypass
        r0_if.cmd_valid = 1; r0_if.cmd_addr = 16'h0040;
        step(); step();
        r0_if.cmd_addr = 16'h0048;
        #1;
        chk("t4_outs_cnt_full", 32'(outs_cnt), 2);
        chk("t4_dt_cmd_valid_full", 32'(dt_if.cmd_valid), 0);
        chk("t4_r0_cmd_ready_full", 32'(r0_if.cmd_ready), 0);
        chk("t4_arb_active", 32'(arb_active), 1);
        dt_if.rsp_valid = 1; dt_if.rsp_rdata = 32'h0000_0011;
        #1;
        chk("t4_no_bypass", 32'(dt_if.cmd_valid), 0);
        chk("t4_r0_rsp_valid", 32'(r0_if.rsp_valid), 1);
        step();
        dt_if.rsp_valid = 0;
        #1;
        chk("t4_outs_cnt_pop", 32'(outs_cnt), 1);
        chk("t4_dt_cmd_valid_next", 32'(dt_if.cmd_valid), 1);
        chk("t4_r0_cmd_ready_next", 32'(r0_if.cmd_ready), 1);
        step();
        r0_if.cmd_valid = 0;
        #1;
        chk("t4_outs_cnt_refill", 32'(outs_cnt), 2);

        // 5: response backpressure from r0
        r0_if.rsp_ready = 0;
        dt_if.rsp_valid = 1; dt_if.rsp_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t5_dt_rsp_ready_hold", 32'(dt_if.rsp_ready), 0);
            chk("t5_r0_rsp_valid_hold", 32'(r0_if.rsp_valid), 1);
            step();
            chk("t5_outs_cnt_hold", 32'(outs_cnt), 2);
        end
        r0_if.rsp_ready = 1;
        #1;
        chk("t5_dt_rsp_ready", 32'(dt_if.rsp_ready), 1);
        chk("t5_r0_rdata", r0_if.rsp_rdata, 32'hDEAD_BEEF);
        step();
        chk("t5_outs_cnt_pop", 32'(outs_cnt), 1);
        step();
        dt_if.rsp_valid = 0;
        #1;
        chk("t5_outs_cnt_empty", 32'(outs_cnt), 0);

        // 6: spurious response, sticky error, async reset mid-burst
        dt_if.rsp_valid = 1;
        #1;
        chk("t6_dt_rsp_ready", 32'(dt_if.rsp_ready), 1);
        chk("t6_r0_rsp_valid", 32'(r0_if.rsp_valid), 0);
        chk("t6_r1_rsp_valid", 32'(r1_if.rsp_valid), 0);
        chk("t6_err_before", 32'(arb_err), 0);
        step();
        dt_if.rsp_valid = 0;
        chk("t6_err_set", 32'(arb_err), 1);
        step();
        chk("t6_err_sticky", 32'(arb_err), 1);
        r0_if.cmd_valid = 1; r0_if.cmd_addr = 16'h0080;
        step(); step();
        chk("t6_outs_cnt_burst", 32'(outs_cnt), 2);
        #2;
        rst_n = 0;
        #1;
        chk("t6_async_outs_cnt", 32'(outs_cnt), 0);
        chk("t6_async_arb_err", 32'(arb_err), 0);
        r0_if.cmd_valid = 0;
        step();
        rst_n = 1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
